// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared defaults and helpers for the FFT output reorder
//                buffer: frame/lane/width defaults, complex sample type and
//                an L-bit index reversal function.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int N_POINTS = 512;  // FFT frame length
  localparam int LANES    = 16;   // samples per beat
  localparam int DW       = 16;   // signed width of each re/im component

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // Reverses the low l bits of idx; bits above l come back as zero.
  // Peels idx from its LSB and shifts into r from the LSB, so idx[0]
  // lands in r[l-1].
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int l);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    v = idx;
    for (int i = 0; i < 32; i++) begin
      if (i < l) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_reorder_buf_if
//  Description : Input block stream (no backpressure), output beat stream
//                (valid/ready) and sticky status flags of the reorder buffer.
//  Ports       : in_valid/in_sof/in_re/in_im   - butterfly block input
//                out_valid/out_ready/out_sof/out_eof/out_re/out_im - output
//                overflow/sync_err             - sticky error flags
//                master = producer/consumer side, slave = reorder buffer
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft_reorder_buf_if #(
  parameter int LANES = fft_pkg::LANES,
  parameter int DW    = fft_pkg::DW
);
  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] in_re [LANES];
  logic signed [DW-1:0] in_im [LANES];

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sof;
  logic                 out_eof;
  logic signed [DW-1:0] out_re [LANES];
  logic signed [DW-1:0] out_im [LANES];

  logic                 overflow;
  logic                 sync_err;

  modport master (
    output in_valid, in_sof, in_re, in_im, out_ready,
    input  out_valid, out_sof, out_eof, out_re, out_im, overflow, sync_err
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_im, out_ready,
    output out_valid, out_sof, out_eof, out_re, out_im, overflow, sync_err
  );
endinterface
`default_nettype wire

// File: rtl/fft_pingpong_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pingpong_mem
//  Description : Two-bank flop-based frame store. The write port takes one
//                sample per lane at an independent address (scatter); the
//                read port returns LANES contiguous samples of one block.
//  Ports       : clk              - clock
//                i_we/i_wbank     - write enable, bank select
//                i_waddr[]        - per-lane sample address within the bank
//                i_wre[]/i_wim[]  - per-lane write data
//                i_rbank/i_rblk   - read bank and block index
//                o_rre[]/o_rim[]  - combinational read data
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_pingpong_mem #(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int LANES    = fft_pkg::LANES,
  parameter int DW       = fft_pkg::DW,
  localparam int AW      = $clog2(N_POINTS),
  localparam int BW      = $clog2(N_POINTS / LANES),
  localparam int LW      = $clog2(LANES)
) (
  input  wire logic                 clk,
  input  wire logic                 i_we,
  input  wire logic                 i_wbank,
  input  wire logic [AW-1:0]        i_waddr [LANES],
  input  wire logic signed [DW-1:0] i_wre   [LANES],
  input  wire logic signed [DW-1:0] i_wim   [LANES],
  input  wire logic                 i_rbank,
  input  wire logic [BW-1:0]        i_rblk,
  output logic signed [DW-1:0]      o_rre   [LANES],
  output logic signed [DW-1:0]      o_rim   [LANES]
);

  // {re, im} packed per sample
  logic [2*DW-1:0] r_mem [2][N_POINTS];
  logic [2*DW-1:0] w_rword [LANES];

  // Lane addresses within one block are always distinct (they differ in the
  // reversed lane bits), so the per-lane writes never collide.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int j = 0; j < LANES; j++) begin
        r_mem[i_wbank][i_waddr[j]] <= {i_wre[j], i_wim[j]};
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_rd
    assign w_rword[j] = r_mem[i_rbank][{i_rblk, LW'(j)}];
    assign o_rre[j]   = w_rword[j][2*DW-1:DW];
    assign o_rim[j]   = w_rword[j][DW-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/fft_reorder_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fft_reorder_buf
//  Description : Scatters bit-reversed FFT output blocks into a ping-pong
//                frame store and streams complete frames out in natural
//                order, LANES samples per beat, with valid/ready handshake.
//  Ports       : clk  - clock
//                rstn - synchronous active-low reset
//                bus  - fft_reorder_buf_if.slave (input blocks, output
//                       beats, sticky overflow / sync_err)
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_buf
  import fft_pkg::*;
#(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int LANES    = fft_pkg::LANES,
  parameter int DW       = fft_pkg::DW
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  fft_reorder_buf_if.slave   bus
);

  localparam int NB = N_POINTS / LANES;
  localparam int AW = $clog2(N_POINTS);
  localparam int BW = $clog2(NB);
  localparam int LW = $clog2(LANES);
  localparam logic [BW-1:0] c_blk_last = BW'(NB - 1);

  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic [BW-1:0]        r_wr_cnt;
  logic [BW-1:0]        r_rd_cnt;
  logic [1:0]           r_full;
  logic                 r_out_valid;
  logic                 r_out_sof;
  logic                 r_out_eof;
  logic signed [DW-1:0] r_out_re [LANES];
  logic signed [DW-1:0] r_out_im [LANES];
  logic                 r_overflow;
  logic                 r_sync_err;

  logic                 w_wr_ok;
  logic [BW-1:0]        w_wblk;
  logic                 w_wr_last;
  logic                 w_load;
  logic                 w_rd_last;
  logic [1:0]           w_full_nxt;
  logic [AW-1:0]        w_waddr [LANES];
  logic signed [DW-1:0] w_rre   [LANES];
  logic signed [DW-1:0] w_rim   [LANES];

  // An sof always restarts at block 0, whether or not the frame was partial;
  // the stale partial data is simply overwritten by the new frame.
  assign w_wr_ok   = bus.in_valid && !r_full[r_wr_bank];
  assign w_wblk    = bus.in_sof ? '0 : r_wr_cnt;
  assign w_wr_last = w_wr_ok && (w_wblk == c_blk_last);

  assign w_load    = r_full[r_rd_bank] && (!r_out_valid || bus.out_ready);
  assign w_rd_last = w_load && (r_rd_cnt == c_blk_last);

  // Writer only touches a non-full bank and reader only clears a full one,
  // so the set and clear can never target the same bit on one edge.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      w_waddr[j] = AW'(bitrev(32'({w_wblk, LW'(j)}), AW));
    end
  end

  fft_pingpong_mem #(
    .N_POINTS (N_POINTS),
    .LANES    (LANES),
    .DW       (DW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_wbank (r_wr_bank),
    .i_waddr (w_waddr),
    .i_wre   (bus.in_re),
    .i_wim   (bus.in_im),
    .i_rbank (r_rd_bank),
    .i_rblk  (r_rd_cnt),
    .o_rre   (w_rre),
    .o_rim   (w_rim)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_full      <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_re    <= '{default: '0};
      r_out_im    <= '{default: '0};
      r_overflow  <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_cnt <= w_wr_last ? '0 : w_wblk + 1'b1;
        if (bus.in_sof && (r_wr_cnt != '0)) r_sync_err <= 1'b1;
      end
      if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      if (bus.in_valid && r_full[r_wr_bank]) r_overflow <= 1'b1;

      r_full <= w_full_nxt;

      if (w_load) begin
        r_out_re    <= w_rre;
        r_out_im    <= w_rim;
        r_out_sof   <= (r_rd_cnt == '0);
        r_out_eof   <= (r_rd_cnt == c_blk_last);
        r_out_valid <= 1'b1;
        r_rd_cnt    <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_sof   = r_out_sof;
  assign bus.out_eof   = r_out_eof;
  assign bus.overflow  = r_overflow;
  assign bus.sync_err  = r_sync_err;

  for (genvar j = 0; j < LANES; j++) begin : g_out
    assign bus.out_re[j] = r_out_re[j];
    assign bus.out_im[j] = r_out_im[j];
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_reorder_buf
//  Description : Scoreboard bench for fft_reorder_buf. Stimulus pushes the
//                natural-order beats of every frame expected to survive;
//                a negedge monitor pops and compares on each handshake and
//                checks that stalled beats hold steady.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_reorder_buf;

  localparam int N     = 512;
  localparam int LANES = 16;
  localparam int DW    = 16;
  localparam int NB    = N / LANES;
  localparam int LBITS = 9;

  typedef struct packed {
    logic                       sof;
    logic                       eof;
    logic [LANES-1:0][DW-1:0]   re;
    logic [LANES-1:0][DW-1:0]   im;
  } beat_t;

  logic clk;
  logic rstn;
  fft_reorder_buf_if #(.LANES(LANES), .DW(DW)) bus ();

  fft_reorder_buf #(.N_POINTS(N), .LANES(LANES), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  int    n_beats  = 0;
  int    rmode    = 0;  // 0: ready=1, 1: toggle, 2: random, 3: ready=0
  beat_t exp_q[$];

  logic signed [DW-1:0] f_re [N];
  logic signed [DW-1:0] f_im [N];

  // Natural index k holds the sample that arrived at position rev(k).
  function automatic int rev(input int k);
    int r = 0;
    for (int i = 0; i < LBITS; i++) r += ((k >> i) & 1) << (LBITS - 1 - i);
    return r;
  endfunction

  function automatic beat_t cap();
    beat_t b;
    b.sof = bus.out_sof;
    b.eof = bus.out_eof;
    for (int j = 0; j < LANES; j++) begin
      b.re[j] = bus.out_re[j];
      b.im[j] = bus.out_im[j];
    end
    return b;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  // Ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  beat_t mon_got, mon_exp, mon_snap;
  bit    mon_stall = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      mon_stall = 1'b0;
    end else begin
      mon_got = cap();
      if (mon_stall) begin
        n_checks++;
        if (!bus.out_valid || mon_got != mon_snap) begin
          n_errors++;
          $display("FAIL stall_hold: valid=%0b sof=%0b re0=%0d im0=%0d, required held valid=1 sof=%0b re0=%0d im0=%0d",
                   bus.out_valid, mon_got.sof, $signed(mon_got.re[0]), $signed(mon_got.im[0]),
                   mon_snap.sof, $signed(mon_snap.re[0]), $signed(mon_snap.im[0]));
        end
      end
      mon_stall = bus.out_valid && !bus.out_ready;
      mon_snap  = mon_got;
      if (bus.out_valid && bus.out_ready) begin
        n_beats++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat: got sof=%0b re0=%0d, required no beat",
                   mon_got.sof, $signed(mon_got.re[0]));
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got != mon_exp) begin
            int ln = 0;
            for (int j = LANES - 1; j >= 0; j--)
              if (mon_got.re[j] != mon_exp.re[j] || mon_got.im[j] != mon_exp.im[j]) ln = j;
            n_errors++;
            $display("FAIL beat %0d lane %0d: got re=%0d im=%0d sof=%0b eof=%0b, required re=%0d im=%0d sof=%0b eof=%0b",
                     n_beats, ln, $signed(mon_got.re[ln]), $signed(mon_got.im[ln]), mon_got.sof, mon_got.eof,
                     $signed(mon_exp.re[ln]), $signed(mon_exp.im[ln]), mon_exp.sof, mon_exp.eof);
          end
        end
      end
    end
  end

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      bus.in_re[j] = '0;
      bus.in_im[j] = '0;
    end
  endtask

  // Sends nblk blocks of a fresh frame (ramp or random). When expect_it is
  // set the natural-order beats of the frame are queued once it is complete.
  task automatic send_frame(input bit ramp, input int nblk, input bit expect_it, input bit gaps);
    beat_t e;
    for (int p = 0; p < N; p++) begin
      f_re[p] = ramp ? DW'(p)  : DW'($urandom);
      f_im[p] = ramp ? DW'(-p) : DW'($urandom);
    end
    for (int b = 0; b < nblk; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_sof   = (b == 0);
      for (int j = 0; j < LANES; j++) begin
        bus.in_re[j] = f_re[b*LANES + j];
        bus.in_im[j] = f_im[b*LANES + j];
      end
      @(posedge clk); #1;
    end
    idle_in();
    if (expect_it) begin
      for (int m = 0; m < NB; m++) begin
        e.sof = (m == 0);
        e.eof = (m == NB - 1);
        for (int j = 0; j < LANES; j++) begin
          e.re[j] = f_re[rev(m*LANES + j)];
          e.im[j] = f_im[rev(m*LANES + j)];
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string nm);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_idle_valid"}, int'(bus.out_valid), 0);
  endtask

  // At most one frame outstanding guarantees the next frame's bank is free.
  task automatic wait_space();
    int cyc = 0;
    while (exp_q.size() > NB && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("wait_space_timeout", int'(exp_q.size() > NB), 0);
  endtask

  function automatic int out_nonzero();
    beat_t b = cap();
    return int'(b != '0);
  endfunction

  int beats0;

  initial begin
    rstn = 1'b0;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_sof_eof", int'({bus.out_valid, bus.out_sof, bus.out_eof}), 0);
    chk("reset_flags", int'({bus.overflow, bus.sync_err}), 0);
    chk("reset_data", out_nonzero(), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Ramp frame with latency check
    rmode = 0;
    send_frame(1'b1, NB, 1'b1, 1'b0);
    chk("latency_edge_t1", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("latency_edge_t2", int'({bus.out_valid, bus.out_sof}), 3);
    drain("ramp");

    // Toggling backpressure
    rmode = 1;
    send_frame(1'b0, NB, 1'b1, 1'b0);
    drain("toggle");

    // Random backpressure and random input gaps
    rmode = 2;
    for (int f = 0; f < 4; f++) begin
      wait_space();
      send_frame(1'b0, NB, 1'b1, 1'b1);
    end
    drain("random");
    chk("random_overflow", int'(bus.overflow), 0);

    // Back-to-back frames
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    beats0 = n_beats;
    for (int f = 0; f < 3; f++) send_frame(1'b0, NB, 1'b1, 1'b0);
    drain("b2b");
    chk("b2b_beats", n_beats - beats0, 3*NB);
    chk("b2b_overflow", int'(bus.overflow), 0);
    chk("b2b_sync_err", int'(bus.sync_err), 0);

    // Overflow: third frame dropped while both banks are held
    rmode = 3;
    repeat (2) @(posedge clk);
    #1;
    beats0 = n_beats;
    send_frame(1'b0, NB, 1'b1, 1'b0);
    send_frame(1'b0, NB, 1'b1, 1'b0);
    send_frame(1'b0, NB, 1'b0, 1'b0);
    chk("ovf_flag", int'(bus.overflow), 1);
    chk("ovf_held_first", int'({bus.out_valid, bus.out_sof}), 3);
    rmode = 0;
    drain("ovf");
    chk("ovf_beats", n_beats - beats0, 2*NB);

    // Resync: sof arrives after 10 blocks of a partial frame
    send_frame(1'b0, 10, 1'b0, 1'b0);
    chk("resync_no_err_yet", int'(bus.sync_err), 0);
    send_frame(1'b0, NB, 1'b1, 1'b0);
    chk("resync_flag", int'(bus.sync_err), 1);
    drain("resync");

    // Reset in the middle of output
    send_frame(1'b0, NB, 1'b1, 1'b0);
    begin
      int cyc = 0;
      while (exp_q.size() > 20 && cyc < 500) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("midout_valid_before_reset", int'(bus.out_valid), 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midreset_valid_sof_eof", int'({bus.out_valid, bus.out_sof, bus.out_eof}), 0);
    chk("midreset_flags", int'({bus.overflow, bus.sync_err}), 0);
    chk("midreset_data", out_nonzero(), 0);
    exp_q.delete();
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_no_output", int'(bus.out_valid), 0);
    beats0 = n_beats;
    send_frame(1'b1, NB, 1'b1, 1'b0);
    drain("post_reset");
    chk("post_reset_beats", n_beats - beats0, NB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
